// File: rtl/debug_sync_filter_shift_reg.sv
// -----------------------------------------------------------------------------
// debug_sync_filter_shift_reg
//
// Brings WIDTH independent asynchronous level inputs (debug, halt and
// interrupt lines) into the clock domain. Each channel passes through a
// DEPTH-stage synchronizer chain and then a stability filter. A new
// synchronized value must persist for FILTER further cycles before io_q
// accepts it. Registered rise/fall pulses mark every accepted change.
//
// Ports
//   clock     : sole clock
//   reset     : synchronous, active-high reset
//   io_d      : [WIDTH] asynchronous channel inputs
//   io_hold   : freezes the filter state and io_q while high (the sync chain
//               keeps running)
//   io_q      : [WIDTH] synchronized, filtered level
//   io_rise   : [WIDTH] one-cycle pulse when io_q goes 0->1
//   io_fall   : [WIDTH] one-cycle pulse when io_q goes 1->0
//   io_stable : high when every channel has all of its sync stages equal to
//               io_q and an idle filter counter
// -----------------------------------------------------------------------------
module debug_sync_filter_shift_reg #(
    parameter int              WIDTH  = 1,
    parameter int              DEPTH  = 3,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int              FILTER = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_d,
    input  logic             io_hold,
    output logic [WIDTH-1:0] io_q,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall,
    output logic             io_stable
);

    // The counter only has to reach FILTER. For FILTER=0 a one-bit counter
    // is kept so the logic has no zero-width vectors. In that case it never
    // leaves zero.
    localparam int CNT_W = (FILTER > 0) ? $clog2(FILTER + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER);

    // Synchronizer chain: stage 0 samples io_d, and the last stage feeds the
    // filter. The chain keeps shifting during io_hold, so the filter sees
    // current data as soon as the hold ends.
    logic [WIDTH-1:0] sync_reg [DEPTH];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] ch_settled;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                sync_reg[k] <= INIT;
            end
        end else begin
            sync_reg[0] <= io_d;
            for (int k = 1; k < DEPTH; k++) begin
                sync_reg[k] <= sync_reg[k-1];
            end
        end
    end

    assign sync_out = sync_reg[DEPTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic             f_reg;
            logic             rise_reg;
            logic             fall_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             settled;

            always_ff @(posedge clock) begin
                if (reset) begin
                    // Reset discards any pending change and never pulses.
                    f_reg    <= INIT[gi];
                    cnt_reg  <= '0;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else if (io_hold) begin
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else if (sync_out[gi] == f_reg) begin
                    // The input has returned to the accepted level, so a
                    // glitch shorter than the filter window is dropped.
                    cnt_reg  <= '0;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else if (cnt_reg == CNT_LAST) begin
                    f_reg    <= sync_out[gi];
                    cnt_reg  <= '0;
                    rise_reg <= sync_out[gi];
                    fall_reg <= ~sync_out[gi];
                end else begin
                    cnt_reg  <= cnt_reg + 1'b1;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end
            end

            // A channel is settled only when nothing is still travelling
            // down its chain and the filter is idle.
            always_comb begin
                settled = (cnt_reg == '0);
                for (int k = 0; k < DEPTH; k++) begin
                    if (sync_reg[k][gi] != f_reg) begin
                        settled = 1'b0;
                    end
                end
            end

            assign io_q[gi]       = f_reg;
            assign io_rise[gi]    = rise_reg;
            assign io_fall[gi]    = fall_reg;
            assign ch_settled[gi] = settled;
        end
    endgenerate

    assign io_stable = &ch_settled;

endmodule

// File: tb/tb_debug_sync_filter_shift_reg.sv
// -----------------------------------------------------------------------------
// Directed testbench for debug_sync_filter_shift_reg.
// DUT A: WIDTH=4, DEPTH=3, FILTER=2, INIT=4'b0101
// DUT B: WIDTH=1, DEPTH=2, FILTER=0, INIT=0
// Edge numbers in the comments count rising edges after the most recent
// input change. Inputs are driven 1 time unit after an edge, and outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_debug_sync_filter_shift_reg;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_a, hold_a, stable_a;
    logic [3:0] d_a, q_a, rise_a, fall_a;

    logic       reset_b, hold_b, stable_b;
    logic [0:0] d_b, q_b, rise_b, fall_b;

    int n_checks = 0;
    int n_errors = 0;

    debug_sync_filter_shift_reg #(
        .WIDTH (4),
        .DEPTH (3),
        .INIT  (4'b0101),
        .FILTER(2)
    ) dut_a (
        .clock    (clock),
        .reset    (reset_a),
        .io_d     (d_a),
        .io_hold  (hold_a),
        .io_q     (q_a),
        .io_rise  (rise_a),
        .io_fall  (fall_a),
        .io_stable(stable_a)
    );

    debug_sync_filter_shift_reg #(
        .WIDTH (1),
        .DEPTH (2),
        .INIT  (1'b0),
        .FILTER(0)
    ) dut_b (
        .clock    (clock),
        .reset    (reset_b),
        .io_d     (d_b),
        .io_hold  (hold_b),
        .io_q     (q_b),
        .io_rise  (rise_b),
        .io_fall  (fall_b),
        .io_stable(stable_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_a(input string tag, input logic [3:0] q, input logic [3:0] r,
                            input logic [3:0] f);
        $display("[%0t] A %s: d=%b q=%b rise=%b fall=%b stable=%b",
                 $time, tag, d_a, q_a, rise_a, fall_a, stable_a);
        check({tag, "_q"},    q_a,    q);
        check({tag, "_rise"}, rise_a, r);
        check({tag, "_fall"}, fall_a, f);
    endtask

    task automatic expect_b(input string tag, input logic q, input logic r, input logic f);
        $display("[%0t] B %s: d=%b q=%b rise=%b fall=%b stable=%b",
                 $time, tag, d_b, q_b, rise_b, fall_b, stable_b);
        check({tag, "_q"},    q_b,    q);
        check({tag, "_rise"}, rise_b, r);
        check({tag, "_fall"}, fall_b, f);
    endtask

    initial begin
        reset_a = 1'b1; hold_a = 1'b0; d_a = 4'b1010;
        reset_b = 1'b1; hold_b = 1'b0; d_b = 1'b0;

        // ---- 1: reset, then acceptance of 1010 with latency DEPTH+1+FILTER = 6
        tick(2);
        expect_a("t1_reset", 4'b0101, 4'b0000, 4'b0000);
        check("t1_reset_stable", stable_a, 1'b1);
        expect_b("t3_reset", 1'b0, 1'b0, 1'b0);
        check("t3_reset_stable", stable_b, 1'b1);
        reset_a = 1'b0; reset_b = 1'b0;
        tick(1);                                  // edge 1
        check("t1_e1_stable", stable_a, 1'b0);
        tick(4);                                  // edge 5
        expect_a("t1_e5", 4'b0101, 4'b0000, 4'b0000);
        tick(1);                                  // edge 6
        expect_a("t1_e6", 4'b1010, 4'b1010, 4'b0101);
        check("t1_e6_stable", stable_a, 1'b1);
        tick(1);                                  // edge 7
        expect_a("t1_e7", 4'b1010, 4'b0000, 4'b0000);
        check("t1_e7_stable", stable_a, 1'b1);

        // ---- 2a: a 2-cycle pulse on d[0] is no longer than FILTER and is dropped
        d_a = 4'b1011;
        tick(2);
        d_a = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            expect_a("t2_glitch", 4'b1010, 4'b0000, 4'b0000);
        end
        check("t2_glitch_stable", stable_a, 1'b1);

        // ---- 2b: a 4-cycle pulse is accepted (rise at edge 6, fall at edge 10)
        d_a = 4'b1011;
        tick(4);
        d_a = 4'b1010;
        tick(1);                                  // edge 5
        expect_a("t2_e5", 4'b1010, 4'b0000, 4'b0000);
        tick(1);                                  // edge 6
        expect_a("t2_e6", 4'b1011, 4'b0001, 4'b0000);
        tick(1);                                  // edge 7
        expect_a("t2_e7", 4'b1011, 4'b0000, 4'b0000);
        tick(2);                                  // edge 9
        expect_a("t2_e9", 4'b1011, 4'b0000, 4'b0000);
        tick(1);                                  // edge 10
        expect_a("t2_e10", 4'b1010, 4'b0000, 4'b0001);
        tick(1);
        expect_a("t2_e11", 4'b1010, 4'b0000, 4'b0000);

        // ---- 6: simultaneous events. First move to 0010, then to 1001.
        d_a = 4'b0010;
        tick(6);
        expect_a("t6_pre", 4'b0010, 4'b0000, 4'b1000);
        tick(1);
        expect_a("t6_pre_quiet", 4'b0010, 4'b0000, 4'b0000);
        d_a = 4'b1001;
        tick(1);                                  // edge 1
        check("t6_e1_stable", stable_a, 1'b0);
        tick(3);                                  // edge 4, counters at 1
        expect_a("t6_e4", 4'b0010, 4'b0000, 4'b0000);
        check("t6_e4_stable", stable_a, 1'b0);
        tick(1);                                  // edge 5, counters at 2
        check("t6_e5_stable", stable_a, 1'b0);
        tick(1);                                  // edge 6
        expect_a("t6_e6", 4'b1001, 4'b1001, 4'b0010);
        check("t6_e6_stable", stable_a, 1'b1);

        // ---- 4: hold. Counters reach 1 at edge 4, are frozen over edges 5..9,
        //         resume at edge 10 (cnt 2) and accept at edge 11.
        d_a = 4'b0110;
        tick(4);                                  // edge 4
        expect_a("t4_e4", 4'b1001, 4'b0000, 4'b0000);
        hold_a = 1'b1;
        for (int i = 0; i < 5; i++) begin         // edges 5..9
            tick(1);
            expect_a("t4_held", 4'b1001, 4'b0000, 4'b0000);
            check("t4_held_stable", stable_a, 1'b0);
        end
        hold_a = 1'b0;
        tick(1);                                  // edge 10
        expect_a("t4_e10", 4'b1001, 4'b0000, 4'b0000);
        tick(1);                                  // edge 11
        expect_a("t4_e11", 4'b0110, 4'b0110, 4'b1001);

        // ---- 5: reset at edge 5 mid-count. Change reappears 6 edges later.
        d_a = 4'b1111;
        tick(4);
        reset_a = 1'b1;
        tick(1);                                  // edge 5 (reset)
        expect_a("t5_reset", 4'b0101, 4'b0000, 4'b0000);
        check("t5_reset_stable", stable_a, 1'b1);
        reset_a = 1'b0;
        tick(5);                                  // edge 10
        expect_a("t5_e10", 4'b0101, 4'b0000, 4'b0000);
        tick(1);                                  // edge 11
        expect_a("t5_e11", 4'b1111, 4'b1010, 4'b0000);

        // ---- hold together with reset: reset wins
        hold_a = 1'b1; reset_a = 1'b1;
        tick(1);
        expect_a("thr_reset", 4'b0101, 4'b0000, 4'b0000);
        hold_a = 1'b0; reset_a = 1'b0;
        tick(1);                                  // edge 1 after release
        expect_a("thr_e1", 4'b0101, 4'b0000, 4'b0000);
        tick(5);                                  // edge 6
        expect_a("thr_e6", 4'b1111, 4'b1010, 4'b0000);

        // ---- 3: DUT B, DEPTH=2 FILTER=0, latency 3
        d_b = 1'b1;
        tick(2);
        expect_b("t3_e2", 1'b0, 1'b0, 1'b0);
        tick(1);
        expect_b("t3_e3", 1'b1, 1'b1, 1'b0);
        tick(1);
        expect_b("t3_e4", 1'b1, 1'b0, 1'b0);
        check("t3_e4_stable", stable_b, 1'b1);
        d_b = 1'b0;
        tick(2);
        expect_b("t3_fall_e2", 1'b1, 1'b0, 1'b0);
        tick(1);
        expect_b("t3_fall_e3", 1'b0, 1'b0, 1'b1);
        // single-cycle pulse propagates: rise, then fall one cycle later
        d_b = 1'b1;
        tick(1);
        d_b = 1'b0;
        tick(1);
        expect_b("t3_pulse_e2", 1'b0, 1'b0, 1'b0);
        tick(1);
        expect_b("t3_pulse_e3", 1'b1, 1'b1, 1'b0);
        tick(1);
        expect_b("t3_pulse_e4", 1'b0, 1'b0, 1'b1);
        tick(1);
        expect_b("t3_pulse_e5", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
